// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubble, EX redirect flush, memory freeze with watchdog,
// saturating stall/flush counters. Define HAZARD_MEM_WAIT_EN to enable the memory freeze/timeout path.
module hazard_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_we,
  input  logic             ex_mem_read,
  input  logic [1:0]       ex_jump_t,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             pc_redirect,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] JT_JAL  = 2'b01;
  localparam logic [1:0] JT_JALR = 2'b10;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

  logic             w_redirect;
  logic             w_load_use;
  logic             w_in_wait;
  logic             w_timeout;
  logic             w_freeze;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_redirect = (ex_jump_t == JT_JAL) || (ex_jump_t == JT_JALR) || ex_branch_taken;
  assign w_load_use = ex_mem_read && ex_reg_we && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

`ifdef HAZARD_MEM_WAIT_EN
  localparam int TMR_W = $clog2(WAIT_MAX);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_nxt;

  assign w_in_wait = (r_state == ST_WAIT);
  assign w_timeout = w_in_wait && (r_timer == TMR_W'(WAIT_MAX - 1)) && !mem_ready;
  assign w_freeze  = mem_req && !mem_ready && !w_timeout;

  always_comb begin
    w_state_nxt = ST_RUN;
    w_timer_nxt = '0;
    if (w_freeze) begin
      w_state_nxt = ST_WAIT;
      w_timer_nxt = w_in_wait ? r_timer + TMR_W'(1) : TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end
`else
  logic w_unused_mem;

  assign w_unused_mem = &{1'b0, mem_req, mem_ready};
  assign w_in_wait    = 1'b0;
  assign w_timeout    = 1'b0;
  assign w_freeze     = 1'b0;
`endif

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    pc_redirect  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    mem_err      = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (w_freeze) begin
      // Redirect/load-use are held off here; frozen stages re-present them after release.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else begin
      // Leaving WAIT (completion or abandon) still bubbles MEM/WB for that cycle.
      mem_wb_flush = w_in_wait;
      mem_err      = w_timeout;
      if (w_redirect) begin
        pc_redirect = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt, !pc_en);
      r_flush_cnt <= sat_inc(r_flush_cnt, pc_redirect);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (WAIT_MAX=8, CNT_W=4); memory-path scenarios
// follow HAZARD_MEM_WAIT_EN.
module tb_hazard_ctrl;
  localparam int WAIT_MAX = 8;
  localparam int CNT_W    = 4;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, pc_redirect, if_id_flush, id_ex_flush, mem_wb_flush, mem_err}
  localparam logic [8:0] C_RST = 9'b000001110;
  localparam logic [8:0] C_NRM = 9'b111100000;
  localparam logic [8:0] C_LU  = 9'b001100100;
  localparam logic [8:0] C_RED = 9'b111111100;
  localparam logic [8:0] C_FRZ = 9'b000000010;
  localparam logic [8:0] C_CMP = 9'b111100010;
  localparam logic [8:0] C_CRD = 9'b111111110;
  localparam logic [8:0] C_TMO = 9'b111100011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_reg_we = 0, ex_mem_read = 0;
  logic [1:0] ex_jump_t = '0;
  logic ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, pc_redirect;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] ctl;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
    .ex_jump_t(ex_jump_t), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .pc_redirect(pc_redirect), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, pc_redirect,
                if_id_flush, id_ex_flush, mem_wb_flush, mem_err};

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_reg_we = 0; ex_mem_read = 0;
    ex_jump_t = '0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1; ex_reg_we = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    #1;
    n_total++; if (ctl !== C_RST) $display("FAIL reset_ctl: got %b expected %b", ctl, C_RST); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL reset_stall: got %0d expected 0", stall_cnt); else n_pass++;
    n_total++; if (flush_cnt !== 4'd0) $display("FAIL reset_flush: got %0d expected 0", flush_cnt); else n_pass++;
    rst_n = 1;
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL reset_release: got %b expected %b", ctl, C_NRM); else n_pass++;
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use();
    #1;
    n_total++; if (ctl !== C_LU) $display("FAIL lu_rs1: got %b expected %b", ctl, C_LU); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd1) $display("FAIL lu_cnt1: got %0d expected 1", stall_cnt); else n_pass++;
    idle();
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL lu_bubble: got %b expected %b", ctl, C_NRM); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd1) $display("FAIL lu_cnt_hold: got %0d expected 1", stall_cnt); else n_pass++;
    set_load_use();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL lu_x0: got %b expected %b", ctl, C_NRM); else n_pass++;
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_use_rs2 = 1;
    #1;
    n_total++; if (ctl !== C_LU) $display("FAIL lu_rs2: got %b expected %b", ctl, C_LU); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd2) $display("FAIL lu_cnt2: got %0d expected 2", stall_cnt); else n_pass++;
    id_use_rs2 = 0; id_rs1 = 5'd7; id_use_rs1 = 0;
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL lu_unused_src: got %b expected %b", ctl, C_NRM); else n_pass++;
    id_use_rs1 = 1; ex_reg_we = 0;
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL lu_no_we: got %b expected %b", ctl, C_NRM); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd2) $display("FAIL lu_cnt_final: got %0d expected 2", stall_cnt); else n_pass++;
  endtask

  task automatic test_redirect();
    apply_reset();
    ex_jump_t = 2'b01;
    #1;
    n_total++; if (ctl !== C_RED) $display("FAIL red_jal: got %b expected %b", ctl, C_RED); else n_pass++;
    tick();
    ex_jump_t = 2'b10;
    #1;
    n_total++; if (ctl !== C_RED) $display("FAIL red_jalr: got %b expected %b", ctl, C_RED); else n_pass++;
    tick();
    ex_jump_t = 2'b00; ex_branch_taken = 1;
    set_load_use();
    #1;
    n_total++; if (ctl !== C_RED) $display("FAIL red_branch_lu: got %b expected %b", ctl, C_RED); else n_pass++;
    tick();
    n_total++; if (flush_cnt !== 4'd3) $display("FAIL red_flush_cnt: got %0d expected 3", flush_cnt); else n_pass++;
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL red_stall_cnt: got %0d expected 0", stall_cnt); else n_pass++;
    idle();
    ex_jump_t = 2'b11;
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL red_jt11: got %b expected %b", ctl, C_NRM); else n_pass++;
    tick();
    n_total++; if (flush_cnt !== 4'd3) $display("FAIL red_cnt_hold: got %0d expected 3", flush_cnt); else n_pass++;
  endtask

`ifdef HAZARD_MEM_WAIT_EN
  task automatic test_freeze();
    apply_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_load_use();
      if (i == 2) begin
        ex_mem_read = 0; ex_reg_we = 0; ex_rd = '0; id_rs1 = '0; id_use_rs1 = 0;
        ex_branch_taken = 1;
      end
      #1;
      n_total++; if (ctl !== C_FRZ) $display("FAIL frz_cycle%0d: got %b expected %b", i, ctl, C_FRZ); else n_pass++;
      tick();
    end
    mem_ready = 1;
    #1;
    n_total++; if (ctl !== C_CRD) $display("FAIL frz_complete: got %b expected %b", ctl, C_CRD); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd3) $display("FAIL frz_stall_cnt: got %0d expected 3", stall_cnt); else n_pass++;
    n_total++; if (flush_cnt !== 4'd1) $display("FAIL frz_flush_cnt: got %0d expected 1", flush_cnt); else n_pass++;
    idle();
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL frz_back_run: got %b expected %b", ctl, C_NRM); else n_pass++;
    mem_req = 1; mem_ready = 1;
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL frz_req_ready: got %b expected %b", ctl, C_NRM); else n_pass++;
    tick();
    idle();
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL frz_no_wait: got %b expected %b", ctl, C_NRM); else n_pass++;
    // Single-cycle freeze then completion: plain completion pattern.
    mem_req = 1;
    #1;
    n_total++; if (ctl !== C_FRZ) $display("FAIL frz_short: got %b expected %b", ctl, C_FRZ); else n_pass++;
    tick();
    mem_ready = 1;
    #1;
    n_total++; if (ctl !== C_CMP) $display("FAIL frz_short_cmp: got %b expected %b", ctl, C_CMP); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_req = 1; mem_ready = 0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < WAIT_MAX - 1; i++) begin
        #1;
        n_total++; if (ctl !== C_FRZ) $display("FAIL tmo_r%0d_frz%0d: got %b expected %b", r, i, ctl, C_FRZ); else n_pass++;
        tick();
      end
      #1;
      n_total++; if (ctl !== C_TMO) $display("FAIL tmo_r%0d_err: got %b expected %b", r, ctl, C_TMO); else n_pass++;
      tick();
      n_total++; if (stall_cnt !== 4'(7 * (r + 1))) $display("FAIL tmo_r%0d_cnt: got %0d expected %0d", r, stall_cnt, 7 * (r + 1)); else n_pass++;
    end
    idle();
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL tmo_after: got %b expected %b", ctl, C_NRM); else n_pass++;
  endtask
`else
  task automatic test_mem_ignored();
    apply_reset();
    mem_req = 1; mem_ready = 0;
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL mem_ign1: got %b expected %b", ctl, C_NRM); else n_pass++;
    tick();
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL mem_ign2: got %b expected %b", ctl, C_NRM); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL mem_ign_cnt: got %0d expected 0", stall_cnt); else n_pass++;
    idle();
  endtask
`endif

  task automatic test_reset_mid();
    apply_reset();
    ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0;
`ifdef HAZARD_MEM_WAIT_EN
    mem_req = 1; mem_ready = 0;
`else
    set_load_use();
`endif
    tick();
    tick();
    n_total++; if (stall_cnt !== 4'd2) $display("FAIL rstm_pre_stall: got %0d expected 2", stall_cnt); else n_pass++;
    rst_n = 0;
    #1;
    n_total++; if (ctl !== C_RST) $display("FAIL rstm_ctl: got %b expected %b", ctl, C_RST); else n_pass++;
    tick();
    n_total++; if (stall_cnt !== 4'd0) $display("FAIL rstm_stall: got %0d expected 0", stall_cnt); else n_pass++;
    n_total++; if (flush_cnt !== 4'd0) $display("FAIL rstm_flush: got %0d expected 0", flush_cnt); else n_pass++;
    n_total++; if (ctl !== C_RST) $display("FAIL rstm_held: got %b expected %b", ctl, C_RST); else n_pass++;
    tick();
    rst_n = 1;
    idle();
    #1;
    n_total++; if (ctl !== C_NRM) $display("FAIL rstm_run: got %b expected %b", ctl, C_NRM); else n_pass++;
  endtask

  task automatic test_saturation();
    apply_reset();
    set_load_use();
    repeat (20) tick();
    n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall: got %0d expected 15", stall_cnt); else n_pass++;
    idle();
    ex_branch_taken = 1;
    repeat (20) tick();
    n_total++; if (flush_cnt !== 4'd15) $display("FAIL sat_flush: got %0d expected 15", flush_cnt); else n_pass++;
    n_total++; if (stall_cnt !== 4'd15) $display("FAIL sat_stall_hold: got %0d expected 15", stall_cnt); else n_pass++;
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
`ifdef HAZARD_MEM_WAIT_EN
    test_freeze();
    test_timeout();
`else
    test_mem_ignored();
`endif
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
